// File: rtl/spi_regbank_pkg.sv
// Shared types and helpers for the SPI register bank.
// Provides the FSM state enum, frame width helper and R/W encoding.
package spi_regbank_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        DATA,
        RDATA,
        DONE
    } state_t;

    localparam logic RW_WRITE = 1'b1;

    function automatic int frame_w(input int addr_w,
                                   input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_regbank_sync_edge.sv
// Synchroniser with registered rise/fall flags for one async input.
// Ports: clk, rst_n (sync, active low), din (async), rise/fall (1-clk flags).
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lvl_q;
    logic                   lvl_s;

    assign lvl_s = sync_q[SYNC_STAGES-1];

    // Flags are registered alongside the level copy, so they appear
    // one clk after the synchronised level changes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            lvl_q  <= RST_VAL;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            lvl_q  <= lvl_s;
            rise   <= lvl_s & ~lvl_q;
            fall   <= ~lvl_s & lvl_q;
        end
    end

endmodule

// File: rtl/spi_regbank.sv
// SPI mode-0 peripheral with a bank of NUM_REGS control registers.
// Ports: clk, rst_n, ncs/sclk/copi (async pins), cipo/cipo_oe (pad),
//        regs_flat (register bank), wr_pulse (per-reg update), frame_err.
module spi_regbank
    import spi_regbank_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int NUM_REGS    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ncs,
    input  logic                       sclk,
    input  logic                       copi,
    output logic                       cipo,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic [NUM_REGS-1:0]        wr_pulse,
    output logic                       frame_err
);

    localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam int SH_W    = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;

    localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] DAT_LAST = CNT_W'(DATA_W - 1);

    logic ncs_rise, ncs_fall;
    logic sclk_rise, sclk_fall;

    logic [SYNC_STAGES-1:0] copi_q;
    logic                   copi_s;

    state_t             state;
    logic [CNT_W-1:0]   bit_cnt;
    logic [SH_W-1:0]    rx_sh;
    logic [DATA_W-1:0]  tx_sh;
    logic [ADDR_W-1:0]  addr_q;
    logic               commit;
    logic [DATA_W-1:0]  regs [NUM_REGS];

    logic [ADDR_W-1:0]  cmd_addr;
    logic               cmd_rw;
    logic [DATA_W-1:0]  rd_val;
    logic               fin;
    logic               abort;

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (1'b1)
    ) u_ncs (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (ncs),
        .rise  (ncs_rise),
        .fall  (ncs_fall)
    );

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (1'b0)
    ) u_sclk (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sclk),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            copi_q <= '0;
        end else begin
            copi_q <= {copi_q[SYNC_STAGES-2:0], copi};
        end
    end

    assign copi_s = copi_q[SYNC_STAGES-1];

    // Command word as it will look once the current bit is shifted in.
    assign cmd_rw   = rx_sh[ADDR_W-1];
    assign cmd_addr = {rx_sh[ADDR_W-2:0], copi_s};

    always_comb begin
        rd_val = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (cmd_addr == ADDR_W'(r)) begin
                rd_val = regs[r];
            end
        end
    end

    // A final data rise beats an ncs rise seen in the same clk.
    assign fin = (state == DATA) && sclk_rise
              && (bit_cnt == DAT_LAST);

    assign abort = ncs_rise && !fin
                && ((state == CMD) || (state == DATA)
                 || (state == RDATA));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            rx_sh     <= '0;
            tx_sh     <= '0;
            addr_q    <= '0;
            commit    <= 1'b0;
            cipo      <= 1'b0;
            cipo_oe   <= 1'b0;
            wr_pulse  <= '0;
            frame_err <= 1'b0;
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            wr_pulse  <= '0;
            frame_err <= 1'b0;
            commit    <= 1'b0;

            for (int r = 0; r < NUM_REGS; r++) begin
                if (commit && (addr_q == ADDR_W'(r))) begin
                    regs[r]     <= rx_sh[DATA_W-1:0];
                    wr_pulse[r] <= 1'b1;
                end
            end

            if (abort) begin
                state     <= IDLE;
                frame_err <= 1'b1;
                cipo_oe   <= 1'b0;
                cipo      <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (ncs_fall) begin
                            state   <= CMD;
                            bit_cnt <= '0;
                            rx_sh   <= '0;
                        end
                    end
                    CMD: begin
                        if (sclk_rise) begin
                            rx_sh <= {rx_sh[SH_W-2:0], copi_s};
                            if (bit_cnt == CMD_LAST) begin
                                bit_cnt <= '0;
                                addr_q  <= cmd_addr;
                                if (cmd_rw == RW_WRITE) begin
                                    state <= DATA;
                                end else begin
                                    state   <= RDATA;
                                    tx_sh   <= rd_val;
                                    cipo_oe <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    DATA: begin
                        if (sclk_rise) begin
                            rx_sh   <= {rx_sh[SH_W-2:0], copi_s};
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                        if (fin) begin
                            commit <= 1'b1;
                            state  <= ncs_rise ? IDLE : DONE;
                        end
                    end
                    RDATA: begin
                        if (sclk_fall) begin
                            cipo  <= tx_sh[DATA_W-1];
                            tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
                            if (bit_cnt == DAT_LAST) begin
                                state <= DONE;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    DONE: begin
                        // cipo keeps the last bit until ncs rises.
                        if (ncs_rise) begin
                            state   <= IDLE;
                            cipo_oe <= 1'b0;
                            cipo    <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_flat
        assign regs_flat[r*DATA_W +: DATA_W] = regs[r];
    end

endmodule
